// File: rtl/conv_output_activation_unpacker.sv
// rtl/conv_output_activation_unpacker.sv - serialise packed conv lanes into activated 16-bit samples
module conv_output_activation_unpacker #(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [1:0]                  act_mode,
  input  logic [DATA_WIDTH*LANES-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        frame_done,
  output logic [15:0]                 sample_count
);

  localparam int IN_W  = DATA_WIDTH * LANES;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IN_W-1:0]       hold_data_q,    hold_data_d;
  logic [1:0]            hold_mode_q,    hold_mode_d;
  logic                  hold_last_q,    hold_last_d;
  logic                  hold_valid_q,   hold_valid_d;
  logic [IDX_W-1:0]      lane_idx_q,     lane_idx_d;
  logic                  frame_done_q,   frame_done_d;
  logic [15:0]           sample_count_q, sample_count_d;
  // Keeps tready low during reset and for the release cycle itself.
  logic                  ready_en_q;

  logic                  last_lane;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [DATA_WIDTH-1:0] lane_raw;
  logic [DATA_WIDTH-1:0] lane_act;

  assign last_lane     = (lane_idx_q == LAST_IDX);
  assign out_xfer      = hold_valid_q & m_axis_tready;
  // Zero-bubble reload: the next beat may land on the same edge the final lane leaves.
  assign s_axis_tready = ready_en_q & (~hold_valid_q | (out_xfer & last_lane));
  assign in_xfer       = s_axis_tvalid & s_axis_tready;

  assign m_axis_tvalid = hold_valid_q;
  assign m_axis_tlast  = hold_valid_q & hold_last_q & last_lane;
  assign m_axis_tdata  = lane_act;
  assign frame_done    = frame_done_q;
  assign sample_count  = sample_count_q;

  // Pick the current lane out of the held beat.
  always_comb begin
    lane_raw = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_idx_q == IDX_W'(k)) begin
        lane_raw = hold_data_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Apply the activation latched with the beat; mode 11 falls through to bypass.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] x;
    x        = $signed(lane_raw);
    lane_act = lane_raw;
    case (hold_mode_q)
      2'b01:   lane_act = x[DATA_WIDTH-1] ? '0 : lane_raw;
      2'b10:   lane_act = x[DATA_WIDTH-1] ? DATA_WIDTH'(x >>> LEAKY_SHIFT) : lane_raw;
      default: lane_act = lane_raw;
    endcase
  end

  // Next-state for the hold register, lane pointer and frame bookkeeping.
  always_comb begin
    hold_data_d    = hold_data_q;
    hold_mode_d    = hold_mode_q;
    hold_last_d    = hold_last_q;
    hold_valid_d   = hold_valid_q;
    lane_idx_d     = lane_idx_q;
    sample_count_d = sample_count_q;
    frame_done_d   = 1'b0;

    if (out_xfer) begin
      if (last_lane) begin
        lane_idx_d   = '0;
        hold_valid_d = 1'b0;
      end else begin
        lane_idx_d   = lane_idx_q + IDX_W'(1);
      end
      if (m_axis_tlast) begin
        sample_count_d = '0;
        frame_done_d   = 1'b1;
      end else begin
        sample_count_d = sample_count_q + 16'd1;
      end
    end

    // A reload overrides the end-of-beat clear so no bubble is inserted.
    if (in_xfer) begin
      hold_data_d  = s_axis_tdata;
      hold_mode_d  = act_mode;
      hold_last_d  = s_axis_tlast;
      hold_valid_d = 1'b1;
      lane_idx_d   = '0;
    end
  end

  // State registers; reset drops any partially emitted beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hold_data_q    <= '0;
      hold_mode_q    <= '0;
      hold_last_q    <= 1'b0;
      hold_valid_q   <= 1'b0;
      lane_idx_q     <= '0;
      frame_done_q   <= 1'b0;
      sample_count_q <= '0;
      ready_en_q     <= 1'b0;
    end else begin
      hold_data_q    <= hold_data_d;
      hold_mode_q    <= hold_mode_d;
      hold_last_q    <= hold_last_d;
      hold_valid_q   <= hold_valid_d;
      lane_idx_q     <= lane_idx_d;
      frame_done_q   <= frame_done_d;
      sample_count_q <= sample_count_d;
      ready_en_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_output_activation_unpacker.sv
// tb/tb_conv_output_activation_unpacker.sv - self-checking bench for conv_output_activation_unpacker
module tb_conv_output_activation_unpacker;

  localparam int LS = 3;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  act_mode = 2'b00;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        frame_done;
  logic [15:0] sample_count;

  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [15:0] log_d[$];
  int          log_t[$];
  int          cyc = 0;
  logic        en_exp = 1'b0;
  int          cnt_exp = 0;
  logic        fd_exp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic        bp_en = 1'b0;
  int          bp_k = 0;
  logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] exp3 [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFF,
                             16'hF000, 16'hFFFF, 16'hFFFE, 16'h7FFF,
                             16'h8000, 16'hFFFF, 16'hFFF0, 16'h7FFF};
  logic [15:0] exp5 [8]  = '{16'h0000, 16'h0000, 16'h0005, 16'h0000,
                             16'h8001, 16'hFFFF, 16'h0005, 16'hFFFE};

  conv_output_activation_unpacker dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .act_mode      (act_mode),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .frame_done    (frame_done),
    .sample_count  (sample_count)
  );

  always #5 clk = ~clk;

  // Cycle stamp and "a clock edge has seen reset released" flag.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    en_exp <= aresetn;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Activation from its arithmetic definition: floor division for the leaky slope.
  function automatic logic [15:0] act_ref(input logic [15:0] raw, input logic [1:0] m);
    int x;
    int y;
    x = int'($signed(raw));
    if (m == 2'b01)      y = (x < 0) ? 0 : x;
    else if (m == 2'b10) y = (x < 0) ? (x - ((1 << LS) - 1)) / (1 << LS) : x;
    else                 y = x;
    return y[15:0];
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [1:0] m);
    int   n;
    logic ok;
    n = 0;
    @(negedge clk);
    s_tdata  = d;
    s_tlast  = l;
    act_mode = m;
    s_tvalid = 1'b1;
    forever begin
      #2;
      ok = s_tvalid & s_tready;
      @(posedge clk);
      if (ok) begin
        for (int k = 0; k < 4; k++) begin
          exp_t e;
          e.data = act_ref(d[k*16 +: 16], m);
          e.last = l && (k == 3);
          q.push_back(e);
        end
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic stop_in();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_log();
    log_d.delete();
    log_t.delete();
  endtask

  function automatic logic [63:0] log_at(input int i);
    return (i < log_d.size()) ? 64'(log_d[i]) : 64'hFFFF_FFFF;
  endfunction

  // Downstream ready: free-running 1,0,0,1 pattern when backpressure is enabled.
  initial begin
    forever begin
      @(negedge clk);
      m_tready = bp_en ? bp_pat[bp_k % 4] : 1'b1;
      bp_k++;
    end
  end

  // Per-cycle compare against the expected-sample queue and frame counters.
  initial begin
    logic xfer;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!aresetn) begin
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_count", 64'(sample_count), 64'd0);
        chk("rst_fdone", 64'(frame_done), 64'd0);
        prev_stall = 1'b0;
        fd_exp     = 1'b0;
        cnt_exp    = 0;
      end else begin
        chk("tvalid", 64'(m_tvalid), 64'(q.size() != 0));
        chk("tready", 64'(s_tready),
            64'(en_exp && (q.size() == 0 || (q.size() == 1 && m_tready))));
        chk("sample_count", 64'(sample_count), 64'(cnt_exp[15:0]));
        chk("frame_done", 64'(frame_done), 64'(fd_exp));
        if (m_tvalid && q.size() != 0) begin
          chk("tdata", 64'(m_tdata), 64'(q[0].data));
          chk("tlast", 64'(m_tlast), 64'(q[0].last));
        end
        if (prev_stall) begin
          chk("stall_tvalid", 64'(m_tvalid), 64'd1);
          chk("stall_tdata", 64'(m_tdata), 64'(prev_data));
          chk("stall_tlast", 64'(m_tlast), 64'(prev_last));
        end
        xfer       = m_tvalid & m_tready;
        prev_stall = m_tvalid & ~m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        fd_exp     = 1'b0;
        if (xfer && q.size() != 0) begin
          e = q.pop_front();
          log_d.push_back(m_tdata);
          log_t.push_back(cyc);
          if (e.last) begin
            cnt_exp = 0;
            fd_exp  = 1'b1;
          end else begin
            cnt_exp = cnt_exp + 1;
          end
        end
      end
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  // Directed scenarios.
  initial begin
    int n;

    // Reset and idle.
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    #3;
    chk("t1_ready_release_cycle", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_ready_after_release", 64'(s_tready), 64'd1);
    chk("t1_tvalid_idle", 64'(m_tvalid), 64'd0);

    // Bypass stream, back-to-back beats.
    clear_log();
    send_beat(64'h0004_0003_0002_0001, 1'b0, 2'b00);
    send_beat(64'h0008_0007_0006_0005, 1'b1, 2'b00);
    stop_in();
    drain();
    chk("t2_len", 64'(log_d.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_sample", log_at(i), 64'(i + 1));
      if (i < log_t.size()) chk("t2_consecutive", 64'(log_t[i] - log_t[0]), 64'(i));
    end
    chk("t2_count_zero", 64'(sample_count), 64'd0);

    // Activation modes on the same lanes.
    clear_log();
    send_beat(64'h7FFF_FFF0_FFFF_8000, 1'b0, 2'b01);
    send_beat(64'h7FFF_FFF0_FFFF_8000, 1'b0, 2'b10);
    send_beat(64'h7FFF_FFF0_FFFF_8000, 1'b1, 2'b11);
    stop_in();
    drain();
    chk("t3_len", 64'(log_d.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk("t3_act", log_at(i), 64'(exp3[i]));

    // Backpressure over three beats.
    clear_log();
    bp_en = 1'b1;
    send_beat(64'h0013_0012_0011_0010, 1'b0, 2'b00);
    send_beat(64'h0017_0016_0015_0014, 1'b0, 2'b00);
    send_beat(64'h001B_001A_0019_0018, 1'b1, 2'b00);
    stop_in();
    drain();
    bp_en = 1'b0;
    chk("t4_len", 64'(log_d.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk("t4_order", log_at(i), 64'(16'h0010 + i));

    // Mode change after acceptance must not affect the held beat.
    clear_log();
    send_beat(64'hFFFE_0005_FFFF_8001, 1'b0, 2'b01);
    @(negedge clk);
    act_mode = 2'b00;
    send_beat(64'hFFFE_0005_FFFF_8001, 1'b1, 2'b00);
    stop_in();
    drain();
    chk("t5_len", 64'(log_d.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("t5_latch", log_at(i), 64'(exp5[i]));

    // Reset in the middle of a beat.
    clear_log();
    send_beat(64'h0044_0033_0022_0011, 1'b0, 2'b00);
    stop_in();
    n = 0;
    while (log_d.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_two_lanes", 64'(log_d.size()), 64'd2);
    aresetn = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("t6_tvalid_after", 64'(m_tvalid), 64'd0);
    chk("t6_count_after", 64'(sample_count), 64'd0);
    chk("t6_no_residual", 64'(log_d.size()), 64'd2);
    clear_log();
    send_beat(64'h0004_0003_0002_0001, 1'b1, 2'b00);
    stop_in();
    drain();
    chk("t6_len", 64'(log_d.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t6_fresh", log_at(i), 64'(i + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
